updown_counter: RTL and testbench

Parametrised up/down counter with runtime limit, wrap or saturate mode, synchronous load, built-in prescaler and N compare channels. It replaces the fixed up-only counter as the shared timing primitive for VGA sync timing, paddle/ball position stepping, score and frame-divider counting. All state is registered on one clock. Compare outputs are decoded from the registered count.

---
 rtl/updown_counter_if.sv | 29 ++
 rtl/updown_counter.sv | 101 ++++++++++
 tb/tb_updown_counter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// Bus bundle for updown_counter: control inputs and count/decode outputs.
interface updown_counter_if #(
  parameter int WIDTH   = 10,
  parameter int NUM_CMP = 2
);
  logic                     en;
  logic [1:0]               ctrl;
  logic [WIDTH-1:0]         load_val;
  logic [WIDTH-1:0]         limit;
  logic                     saturate;
  logic [NUM_CMP*WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0]         Q;
  logic                     roll;
  logic                     at_limit;
  logic                     at_zero;
  logic [NUM_CMP-1:0]       cmp_hit;

  // The controller side drives commands and observes the count.
  modport master (
    output en, ctrl, load_val, limit, saturate, cmp_val,
    input  Q, roll, at_limit, at_zero, cmp_hit
  );

  // The counter side consumes commands and produces the count.
  modport slave (
    input  en, ctrl, load_val, limit, saturate, cmp_val,
    output Q, roll, at_limit, at_zero, cmp_hit
  );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter with runtime limit, wrap/saturate, load, prescaler and
// compare channels. Q and roll are registered; the flags decode from Q.
module updown_counter #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1,
  parameter int NUM_CMP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  updown_counter_if.slave   bus
);

  // A prescaler of 1 still needs a one-bit register so the compare is legal.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_UP   = 2'b01,
    CTRL_DOWN = 2'b10,
    CTRL_LOAD = 2'b11
  } ctrl_t;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    pcnt_next;
  logic             roll;
  logic             roll_next;
  logic             qualify;
  ctrl_t            op;

  // Next-state decode: load beats stepping; a step only fires on the last
  // prescale phase, and every branch keeps Q inside 0..limit.
  always_comb begin
    q_next    = q;
    pcnt_next = pcnt;
    roll_next = 1'b0;
    op        = ctrl_t'(bus.ctrl);
    qualify   = bus.en && ((op == CTRL_UP) || (op == CTRL_DOWN));

    if (op == CTRL_LOAD) begin
      q_next    = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      pcnt_next = '0;
    end else if (qualify) begin
      if (pcnt != PLAST) begin
        pcnt_next = pcnt + 1'b1;
      end else begin
        pcnt_next = '0;
        if (op == CTRL_UP) begin
          if (q < bus.limit) begin
            q_next = q + 1'b1;
          end else if (bus.saturate) begin
            q_next = bus.limit;
          end else begin
            q_next    = '0;
            roll_next = 1'b1;
          end
        end else begin
          if (q > bus.limit) begin
            q_next = bus.limit;
          end else if (q != '0) begin
            q_next = q - 1'b1;
          end else if (bus.saturate) begin
            q_next = '0;
          end else begin
            q_next    = bus.limit;
            roll_next = 1'b1;
          end
        end
      end
    end
  end

  // State register; reset restarts both the count and the prescale phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      pcnt <= '0;
      roll <= 1'b0;
    end else begin
      q    <= q_next;
      pcnt <= pcnt_next;
      roll <= roll_next;
    end
  end

  assign bus.Q        = q;
  assign bus.roll     = roll;
  assign bus.at_limit = (q == bus.limit);
  assign bus.at_zero  = (q == '0);

  // Compare decode against each channel's slice of cmp_val.
  always_comb begin
    bus.cmp_hit = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      bus.cmp_hit[i] = (q == bus.cmp_val[i*WIDTH +: WIDTH]);
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Testbench for updown_counter: directed vector table on a PRESCALE=1
// instance, hand sequences on a PRESCALE=3 instance, then random stimulus
// on both against an arithmetic reference model.
module tb_updown_counter;

  localparam int W = 4;
  localparam int N = 2;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] ctrl;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic       saturate;
  logic [7:0] cmp_val;

  int total;
  int bad;

  // Reference model state per instance (index 0: PRESCALE=1, 1: PRESCALE=3).
  int mq[2];
  int mp[2];
  int mr[2];
  int pre[2];

  updown_counter_if #(.WIDTH(W), .NUM_CMP(N)) bus1 ();
  updown_counter_if #(.WIDTH(W), .NUM_CMP(N)) bus3 ();

  assign bus1.en       = en;
  assign bus1.ctrl     = ctrl;
  assign bus1.load_val = load_val;
  assign bus1.limit    = limit;
  assign bus1.saturate = saturate;
  assign bus1.cmp_val  = cmp_val;
  assign bus3.en       = en;
  assign bus3.ctrl     = ctrl;
  assign bus3.load_val = load_val;
  assign bus3.limit    = limit;
  assign bus3.saturate = saturate;
  assign bus3.cmp_val  = cmp_val;

  updown_counter #(.WIDTH(W), .PRESCALE(1), .NUM_CMP(N)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  updown_counter #(.WIDTH(W), .PRESCALE(3), .NUM_CMP(N)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] ctrl;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic       sat;
    logic [3:0] q;
    logic       roll;
    logic       atl;
    logic       atz;
    logic [1:0] hit;
  } vec_t;

  vec_t vecs[$];

  // Table row builder; flags follow from the expected Q, the row's limit
  // and the fixed compare values 9 (channel 1) and 3 (channel 0).
  task automatic add(input logic r, input logic e, input logic [1:0] c,
                     input int ld, input int lim, input logic s,
                     input int q, input logic rl);
    vec_t v;
    v.rst      = r;
    v.en       = e;
    v.ctrl     = c;
    v.load_val = 4'(ld);
    v.limit    = 4'(lim);
    v.sat      = s;
    v.q        = 4'(q);
    v.roll     = rl;
    v.atl      = (q == lim);
    v.atz      = (q == 0);
    v.hit      = {q == 9, q == 3};
    vecs.push_back(v);
  endtask

  // Spec-level behaviour of one clock edge for both instances.
  task automatic model_edge();
    int lim;
    int ld;
    lim = int'(limit);
    ld  = int'(load_val);
    for (int k = 0; k < 2; k++) begin
      mr[k] = 0;
      if (reset) begin
        mq[k] = 0;
        mp[k] = 0;
      end else if (ctrl == 2'b11) begin
        mq[k] = (ld < lim) ? ld : lim;
        mp[k] = 0;
      end else if (en && ctrl != 2'b00) begin
        if (mp[k] < pre[k] - 1) begin
          mp[k] = mp[k] + 1;
        end else begin
          mp[k] = 0;
          if (ctrl == 2'b01) begin
            if (mq[k] < lim) mq[k] = mq[k] + 1;
            else if (saturate) mq[k] = lim;
            else begin
              mq[k] = 0;
              mr[k] = 1;
            end
          end else begin
            if (mq[k] > lim) mq[k] = lim;
            else if (mq[k] > 0) mq[k] = mq[k] - 1;
            else if (saturate) mq[k] = 0;
            else begin
              mq[k] = lim;
              mr[k] = 1;
            end
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 past the edge.
  task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] c,
                                input logic [3:0] ld, input logic [3:0] lim,
                                input logic s);
    reset    = r;
    en       = e;
    ctrl     = c;
    load_val = ld;
    limit    = lim;
    saturate = s;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int up_seq[12];
    int p3_en[7];
    int p3_q[7];
    logic [1:0] exp_hit;

    total   = 0;
    bad     = 0;
    pre[0]  = 1;
    pre[1]  = 3;
    mq      = '{0, 0};
    mp      = '{0, 0};
    mr      = '{0, 0};
    reset   = 1'b1;
    en      = 1'b0;
    ctrl    = 2'b00;
    load_val = '0;
    limit   = 4'd9;
    saturate = 1'b0;
    cmp_val = {4'd9, 4'd3};

    up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    p3_en  = '{1, 1, 0, 1, 1, 1, 1};
    p3_q   = '{0, 0, 0, 1, 1, 1, 2};

    // Directed table for the PRESCALE=1 instance.
    add(1, 0, 2'b00, 0, 9, 0, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 1, 2'b01, 0, 9, 0, up_seq[i], up_seq[i] == 0);
    add(0, 1, 2'b11, 2, 9, 1, 2, 0);
    add(0, 1, 2'b10, 0, 9, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 2'b10, 0, 9, 1, 0, 0);
    add(0, 1, 2'b11, 7, 9, 0, 7, 0);
    add(0, 1, 2'b01, 0, 5, 0, 0, 1);
    add(0, 1, 2'b11, 7, 9, 1, 7, 0);
    add(0, 1, 2'b01, 0, 5, 1, 5, 0);
    add(0, 1, 2'b11, 7, 9, 0, 7, 0);
    add(0, 1, 2'b10, 0, 5, 0, 5, 0);
    add(0, 1, 2'b11, 7, 9, 1, 7, 0);
    add(0, 1, 2'b10, 0, 5, 1, 5, 0);
    add(0, 0, 2'b11, 12, 9, 0, 9, 0);
    add(0, 1, 2'b01, 0, 0, 0, 0, 1);
    add(0, 1, 2'b01, 0, 0, 0, 0, 1);
    add(0, 1, 2'b10, 0, 0, 0, 0, 1);
    add(0, 1, 2'b01, 0, 0, 1, 0, 0);
    add(0, 0, 2'b01, 0, 9, 0, 0, 0);
    add(0, 1, 2'b11, 5, 9, 0, 5, 0);
    add(0, 0, 2'b10, 0, 9, 0, 5, 0);
    add(0, 1, 2'b00, 0, 9, 0, 5, 0);
    add(0, 1, 2'b11, 0, 9, 0, 0, 0);
    add(0, 1, 2'b10, 0, 9, 0, 9, 1);
    add(0, 1, 2'b10, 0, 9, 0, 8, 0);
    add(1, 1, 2'b11, 5, 9, 0, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].ctrl, vecs[i].load_val,
                     vecs[i].limit, vecs[i].sat);
      check_output($sformatf("vec%0d_q", i), 32'(bus1.Q), 32'(vecs[i].q));
      check_output($sformatf("vec%0d_roll", i), 32'(bus1.roll), 32'(vecs[i].roll));
      check_output($sformatf("vec%0d_at_limit", i), 32'(bus1.at_limit), 32'(vecs[i].atl));
      check_output($sformatf("vec%0d_at_zero", i), 32'(bus1.at_zero), 32'(vecs[i].atz));
      check_output($sformatf("vec%0d_cmp_hit", i), 32'(bus1.cmp_hit), 32'(vecs[i].hit));
    end

    // PRESCALE=3: en gaps freeze the prescale phase.
    apply_stimulus(1'b1, 1'b0, 2'b00, 4'd0, 4'd9, 1'b0);
    check_output("p3_reset_q", 32'(bus3.Q), 32'd0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, 1'(p3_en[i]), 2'b01, 4'd0, 4'd9, 1'b0);
      check_output($sformatf("p3_en_q%0d", i), 32'(bus3.Q), 32'(p3_q[i]));
    end

    // PRESCALE=3: direction change keeps the prescale phase.
    apply_stimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_dir_q0", 32'(bus3.Q), 32'd2);
    apply_stimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd9, 1'b0);
    check_output("p3_dir_q1", 32'(bus3.Q), 32'd2);
    apply_stimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd9, 1'b0);
    check_output("p3_dir_q2", 32'(bus3.Q), 32'd1);

    // PRESCALE=3: reset mid-prescale restarts the phase.
    apply_stimulus(1'b0, 1'b0, 2'b11, 4'd6, 4'd9, 1'b0);
    check_output("p3_load_q", 32'(bus3.Q), 32'd6);
    apply_stimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_mid_q", 32'(bus3.Q), 32'd6);
    apply_stimulus(1'b1, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_rst_q", 32'(bus3.Q), 32'd0);
    check_output("p3_rst_roll", 32'(bus3.roll), 32'd0);
    apply_stimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_after_q0", 32'(bus3.Q), 32'd0);
    apply_stimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_after_q1", 32'(bus3.Q), 32'd0);
    apply_stimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    check_output("p3_after_q2", 32'(bus3.Q), 32'd1);

    // Random stimulus on both instances against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] lim_r;
      logic       sat_r;
      lim_r = limit;
      sat_r = saturate;
      if ($urandom_range(15) == 0) lim_r = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) sat_r = ~sat_r;
      if ($urandom_range(9) == 0) cmp_val = 8'($urandom_range(255));
      apply_stimulus(1'($urandom_range(29) == 0), 1'($urandom_range(3) != 0),
                     2'($urandom_range(3)), 4'($urandom_range(15)), lim_r, sat_r);
      exp_hit = {mq[0] == int'(cmp_val[7:4]), mq[0] == int'(cmp_val[3:0])};
      check_output("rand_p1_q", 32'(bus1.Q), 32'(mq[0]));
      check_output("rand_p1_roll", 32'(bus1.roll), 32'(mr[0]));
      check_output("rand_p1_at_limit", 32'(bus1.at_limit), 32'(mq[0] == int'(limit)));
      check_output("rand_p1_at_zero", 32'(bus1.at_zero), 32'(mq[0] == 0));
      check_output("rand_p1_cmp_hit", 32'(bus1.cmp_hit), 32'(exp_hit));
      exp_hit = {mq[1] == int'(cmp_val[7:4]), mq[1] == int'(cmp_val[3:0])};
      check_output("rand_p3_q", 32'(bus3.Q), 32'(mq[1]));
      check_output("rand_p3_roll", 32'(bus3.roll), 32'(mr[1]));
      check_output("rand_p3_at_limit", 32'(bus3.at_limit), 32'(mq[1] == int'(limit)));
      check_output("rand_p3_at_zero", 32'(bus3.at_zero), 32'(mq[1] == 0));
      check_output("rand_p3_cmp_hit", 32'(bus3.cmp_hit), 32'(exp_hit));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
